// File: rtl/gt_int_serial_ctrl.sv
// Digit-serial signed greater-than: latches one operand pair, walks DIGIT bits per
// cycle LSB-first through a borrow chain, and returns Y = (A > B) behind valid/ready.
module gt_int_serial_ctrl #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y,
  output logic             busy
);

  // Handshake: a pair transfers on a rising edge with in_valid && in_ready, and the
  // result transfers on a rising edge with out_valid && out_ready. Both ready/valid
  // outputs are functions of state only.

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("gt_int_serial_ctrl: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             y_q, y_d;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             chain;

  // Borrow of (B - A) across the current digit; final borrow set means A > B unsigned.
  always_comb begin
    a_dig = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig = b_q[cnt_q*DIGIT +: DIGIT];
    chain = borrow_q;
    for (int i = 0; i < DIGIT; i++) begin
      chain = (a_dig[i] & ~b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & chain);
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d      = {~A[WIDTH-1], A[WIDTH-2:0]};
          b_d      = {~B[WIDTH-1], B[WIDTH-2:0]};
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        borrow_d = chain;
        if (cnt_q == CW'(N - 1)) begin
          y_d     = chain;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      y_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Y         = y_q;

endmodule

// File: tb/tb_gt_int_serial_ctrl.sv
// Directed and random checks of gt_int_serial_ctrl at DIGIT=1 and DIGIT=4, scored
// against a signed-compare model through an expected-result queue.
module tb_gt_int_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        iv, ordy;
  int          sel;
  int          cyc;
  int          n_cmp, n_fail;
  logic [0:0]  exp_q[$];

  logic ir1, ov1, y1, busy1;
  logic ir4, ov4, y4, busy4;
  logic cur_ir, cur_ov, cur_y, cur_busy;

  gt_int_serial_ctrl #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv && (sel == 0)), .in_ready(ir1),
    .A(a), .B(b), .out_valid(ov1), .out_ready((sel == 0) ? ordy : 1'b1),
    .Y(y1), .busy(busy1)
  );

  gt_int_serial_ctrl #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv && (sel == 1)), .in_ready(ir4),
    .A(a), .B(b), .out_valid(ov4), .out_ready((sel == 1) ? ordy : 1'b1),
    .Y(y4), .busy(busy4)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  always_comb begin
    cur_ir   = (sel == 1) ? ir4   : ir1;
    cur_ov   = (sel == 1) ? ov4   : ov1;
    cur_y    = (sel == 1) ? y4    : y1;
    cur_busy = (sel == 1) ? busy4 : busy1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cur_ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, int'(cur_ir), 1);
  endtask

  // Called at a negedge just after the accepting edge; returns edges until out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!cur_ov && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // driver: one full transaction; hold > 0 keeps out_ready low that many cycles.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v,
                         input string tag, input int hold);
    int   lat;
    int   n_exp;
    logic e;
    n_exp = (sel == 1) ? 4 : 16;
    wait_ready(tag);
    a  = ta;
    b  = tb_v;
    iv = 1'b1;
    ordy = (hold > 0) ? 1'b0 : 1'b1;
    exp_q.push_back($signed(ta) > $signed(tb_v));
    @(negedge clk);
    iv = 1'b0;
    a  = 16'($urandom);
    b  = 16'($urandom);
    chk({tag, "_busy"}, int'(cur_busy), 1);
    chk({tag, "_in_ready_run"}, int'(cur_ir), 0);
    wait_out(lat);
    chk({tag, "_latency"}, lat, n_exp);
    e = exp_q.pop_front();
    chk({tag, "_y"}, int'(cur_y), int'(e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_ov"}, int'(cur_ov), 1);
      chk({tag, "_hold_y"}, int'(cur_y), int'(e));
      chk({tag, "_hold_ir"}, int'(cur_ir), 0);
    end
    ordy = 1'b1;
    @(negedge clk);
    chk({tag, "_ov_clear"}, int'(cur_ov), 0);
    chk({tag, "_ir_back"}, int'(cur_ir), 1);
  endtask

  initial begin
    int          acc[3];
    int          lat;
    int          seen_ov;
    logic        e;
    logic [15:0] pa[3];
    logic [15:0] pb[3];
    n_cmp = 0; n_fail = 0; cyc = 0;
    sel = 0; iv = 1'b0; ordy = 1'b1; a = '0; b = '0;
    rst = 1'b1;
    #1;
    chk("rst_ir1", int'(ir1), 1);
    chk("rst_ov1", int'(ov1), 0);
    chk("rst_y1", int'(y1), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_ir4", int'(ir4), 1);
    chk("rst_ov4", int'(ov4), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ir", int'(cur_ir), 1);
    chk("post_rst_busy", int'(cur_busy), 0);

    // basic and sign handling, DIGIT=1
    run_txn(16'd5, 16'd3, "d1_5gt3", 0);
    run_txn(16'd3, 16'd5, "d1_3gt5", 0);
    run_txn(16'hFFFF, 16'h0000, "d1_m1gt0", 0);
    run_txn(16'h7FFF, 16'h8000, "d1_maxgtmin", 0);
    run_txn(16'h8000, 16'h7FFF, "d1_mingtmax", 0);
    run_txn(16'h1234, 16'h1234, "d1_equal", 0);

    // backpressure
    run_txn(16'h0100, 16'hFF00, "d1_bp", 10);

    // back-to-back with in_valid held high; operands scrambled mid-run
    pa[0] = 16'd3;      pb[0] = 16'd2;
    pa[1] = 16'hFFFC;   pb[1] = 16'hFFFD;
    pa[2] = 16'd0;      pb[2] = 16'hFFFF;
    iv = 1'b1;
    ordy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      a = pa[p];
      b = pb[p];
      wait_ready("b2b");
      acc[p] = cyc + 1;
      exp_q.push_back($signed(pa[p]) > $signed(pb[p]));
      @(negedge clk);
      a = ~pa[p];
      b = ~pb[p];
      wait_out(lat);
      chk("b2b_latency", lat, 16);
      e = exp_q.pop_front();
      chk("b2b_y", int'(cur_y), int'(e));
    end
    iv = 1'b0;
    chk("b2b_y_last_is_1", int'(cur_y), 1);
    chk("b2b_gap01", acc[1] - acc[0], 18);
    chk("b2b_gap12", acc[2] - acc[1], 18);
    @(negedge clk);

    // reset mid-run: Y currently 1 from the last pair and must clear
    wait_ready("rst_mid");
    a = 16'd100; b = 16'd0; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_busy_before", int'(cur_busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ir", int'(cur_ir), 1);
    chk("rst_mid_ov", int'(cur_ov), 0);
    chk("rst_mid_y", int'(cur_y), 0);
    chk("rst_mid_busy", int'(cur_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    seen_ov = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cur_ov) seen_ov = 1;
    end
    chk("rst_mid_no_ov", seen_ov, 0);
    run_txn(16'd1, 16'd0, "post_rst_1gt0", 0);

    // random on DIGIT=1
    for (int i = 0; i < 60; i++)
      run_txn(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), "d1_rand", 0);

    // DIGIT=4 instance
    sel = 1;
    @(negedge clk);
    run_txn(16'd5, 16'd3, "d4_5gt3", 0);
    run_txn(16'd3, 16'd5, "d4_3gt5", 0);
    run_txn(16'hFFFF, 16'h0000, "d4_m1gt0", 0);
    run_txn(16'h7FFF, 16'h8000, "d4_maxgtmin", 0);
    run_txn(16'h8000, 16'h7FFF, "d4_mingtmax", 0);
    run_txn(16'h1234, 16'h1234, "d4_equal", 0);
    run_txn(16'hFFFC, 16'hFFFD, "d4_m4gtm3", 0);
    run_txn(16'd0, 16'hFFFF, "d4_0gtm1", 0);
    run_txn(16'h0040, 16'h0040, "d4_bp", 3);
    for (int i = 0; i < 2000; i++)
      run_txn(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), "d4_rand", 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gt_int_serial_ctrl.md
Name: gt_int_serial_ctrl

Overview:
- Digit-serial sequencer for signed integer greater-than (Y = A > B, two's complement).
- Latches one operand pair, walks DIGIT bits per cycle from LSB to MSB through a single DIGIT-wide borrow-chain slice, and returns a 1-bit result.
- Used where a full-width gt_int comparator is too costly. It emulates the bit-serial row-wise evaluation of the PIM targets.
- Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16: operand width in bits, two's complement. Must be at least 2.
- DIGIT, 1: bits processed per cycle. WIDTH must be divisible by DIGIT; elaboration fails otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair on A/B is valid.
- in_ready  output  1  block can accept an operand pair.
- A  input  WIDTH  left operand, signed.
- B  input  WIDTH  right operand, signed.
- out_valid  output  1  Y is valid.
- out_ready  input  1  consumer accepts Y.
- Y  output  1  1 when A > B signed, else 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: while rst is high and immediately after it, all of the following are 0: state=IDLE, in_ready=1, out_valid=0, Y=0, busy=0, and the internal operand registers, borrow and digit counter.
- State machine: IDLE -> RUN -> DONE -> IDLE. Let N = WIDTH/DIGIT.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: latch A and B with the sign bit (bit WIDTH-1) of each inverted. This maps signed order onto unsigned order.
  - Clear borrow=0 and cnt=0, then go to RUN. If in_valid=0, stay in IDLE.
- RUN:
  - in_ready=0. Each edge consumes digit cnt, i.e. bits [cnt*DIGIT +: DIGIT], LSB-first.
  - Per bit i inside the digit, in order: borrow = (a_i & ~b_i) | (~(a_i ^ b_i) & borrow). This is the borrow of B - A.
  - When cnt == N-1, that edge's update is the last. Go to DONE with Y = final borrow. Otherwise cnt++.
  - Exactly N edges are spent in RUN.
- DONE:
  - out_valid=1; Y is held stable.
  - On an edge with out_ready=1, clear out_valid and go to IDLE.
  - If out_ready=0, hold out_valid and Y indefinitely.
- Latency: if accepted at edge k, out_valid rises after edge k+N. With out_ready held at 1, in_ready returns after edge k+N+1, so the minimum issue interval is N+2 cycles.
- in_ready is combinational from state only. It does not depend on in_valid or out_ready.
- Operand stability: A and B are sampled only at the accepting edge. Changes during RUN or DONE have no effect.
- in_valid during RUN or DONE is ignored (not accepted). The producer must hold it until in_ready=1.
- Equal operands give Y=0. A=MIN, B=MAX gives Y=0. A=MAX, B=MIN gives Y=1.
- Reset mid-operation: asserting rst in any state returns to the reset values asynchronously. The in-flight result is discarded and no out_valid pulse is produced.
- The counter is ceil(log2(N)) bits wide, minimum 1 bit. There is no wrap-around beyond N-1.
- busy = (state != IDLE).

Test Plan:
- Basic: A=16'd5, B=16'd3, out_ready=1 -> out_valid rises exactly 16 cycles after accept with Y=1. Swap operands -> Y=0.
- Sign handling: A=16'hFFFF (-1), B=16'h0000 -> Y=0. A=16'h7FFF, B=16'h8000 -> Y=1. A=16'h8000, B=16'h7FFF -> Y=0. A=B=16'h1234 -> Y=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and Y stay stable and in_ready stays 0. Raising out_ready -> one-cycle handshake, then in_ready=1.
- Back-to-back with in_valid held high and out_ready=1: pairs (3,2), (-4,-3), (0,-1) -> Y sequence 1, 0, 1; accepts spaced exactly N+2 cycles apart. Changing A/B mid-RUN does not alter Y.
- DIGIT=4, WIDTH=16: the same vectors give identical Y with latency 4. A 2000-pair random regression against a signed $signed(A) > $signed(B) model shows no mismatch.
- Reset: assert rst at RUN cycle 7 for 1 cycle -> outputs go to their reset values immediately and no out_valid follows. A subsequent transaction (A=1, B=0) -> Y=1 with normal latency.
